// File: rtl/trace_score_scheduler.sv
// trace_score_scheduler
// Arbitrates two record channels into a shared scoring engine. Records are
// accumulated one per accepted transfer; a new-wallet record (or reaching
// MAX_TX records) closes the current wallet with finalize / wait / clear, and
// a held new-wallet record is replayed into the cleared engine afterwards.
// Optional feature macro: TRACE_TIMEOUT_EN (WAIT_DONE watchdog, TIMEOUT_CYC).
module trace_score_scheduler #(
  parameter int MAX_TX      = 100,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [43:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [43:0] req1_data,
  output logic        eng_acc_valid,
  output logic [42:0] eng_acc_data,
  output logic        eng_fin_start,
  input  logic        eng_fin_done,
  output logic        eng_clear,
  output logic [6:0]  tx_count,
  output logic        busy,
  output logic        timeout
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_TX);

  typedef enum logic [2:0] {
    S_IDLE, S_FINALIZE, S_WAIT_DONE, S_CLEAR, S_REPLAY
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [42:0] pend_data_q, pend_data_d;
  logic        acc_vld_q, acc_vld_d;
  logic [42:0] acc_data_q, acc_data_d;
  logic        grant, ready_en, xfer, tmo, wd_expired;
  logic [43:0] rec;

`ifdef TRACE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog counts cycles spent in WAIT_DONE; it restarts on every entry.
  always_comb begin
    wd_cnt_d   = '0;
    wd_expired = 1'b0;
    if (state_q == S_WAIT_DONE) begin
      wd_cnt_d   = wd_cnt_q + 1'b1;
      wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign wd_expired = 1'b0;
`endif

  // Round-robin grant: the pointed-to channel wins if valid, else the other.
  // Intake is closed outside IDLE and while an accumulate pulse is on the bus,
  // so a MAX_TX-reaching accumulate is seen by the engine before finalize.
  always_comb begin
    grant    = ptr_q ? req1_valid : ~req0_valid;
    ready_en = (state_q == S_IDLE) && !acc_vld_q;
    xfer     = ready_en && (grant ? req1_valid : req0_valid);
    rec      = grant ? req1_data : req0_data;
  end

  // Next-state, counter, pending-record and accumulate-pulse logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    acc_vld_d   = 1'b0;
    acc_data_d  = acc_data_q;
    tmo         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_vld_q && cnt_q == MAX_CNT) begin
          state_d = S_FINALIZE;
        end else if (xfer) begin
          ptr_d = ~grant;
          if (rec[43] && cnt_q != 7'd0) begin
            pend_vld_d  = 1'b1;
            pend_data_d = rec[42:0];
            state_d     = S_FINALIZE;
          end else if (cnt_q < MAX_CNT) begin
            acc_vld_d  = 1'b1;
            acc_data_d = rec[42:0];
            cnt_d      = cnt_q + 7'd1;
          end
        end
      end
      S_FINALIZE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (eng_fin_done) begin
          state_d = S_CLEAR;
        end else if (wd_expired) begin
          tmo     = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = 7'd0;
        state_d = pend_vld_q ? S_REPLAY : S_IDLE;
      end
      S_REPLAY: begin
        cnt_d      = 7'd1;
        pend_vld_d = 1'b0;
        state_d    = (MAX_CNT == 7'd1) ? S_FINALIZE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers (reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 7'd0;
      pend_vld_q <= 1'b0;
      acc_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      acc_vld_q  <= acc_vld_d;
    end
  end

  // Data registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
    acc_data_q  <= acc_data_d;
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    req0_ready    = !rst && ready_en && !grant;
    req1_ready    = !rst && ready_en && grant;
    eng_acc_valid = !rst && (acc_vld_q || state_q == S_REPLAY);
    eng_acc_data  = rst ? 43'd0 : ((state_q == S_REPLAY) ? pend_data_q : acc_data_q);
    eng_fin_start = !rst && (state_q == S_FINALIZE);
    eng_clear     = !rst && (state_q == S_CLEAR);
    busy          = !rst && (state_q != S_IDLE);
    timeout       = !rst && tmo;
    tx_count      = rst ? 7'd0 : cnt_q;
  end

endmodule

// File: tb/tb_trace_score_scheduler.sv
// Randomized bench for trace_score_scheduler (MAX_TX=4, default build).
// The reference model is a timeline: each accepted record schedules the
// engine events it implies at absolute cycle numbers.
module tb_trace_score_scheduler;
  localparam int MAXT = 4;
  localparam int NC   = 800;
  localparam int NT   = NC + 24;
  localparam int AS   = NT + 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0_valid, req1_valid, eng_fin_done;
  logic        req0_ready, req1_ready, eng_acc_valid, eng_fin_start, eng_clear;
  logic        busy, timeout;
  logic [43:0] req0_data, req1_data;
  logic [42:0] eng_acc_data;
  logic [6:0]  tx_count;

  trace_score_scheduler #(.MAX_TX(MAXT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .eng_acc_valid(eng_acc_valid), .eng_acc_data(eng_acc_data),
    .eng_fin_start(eng_fin_start), .eng_fin_done(eng_fin_done),
    .eng_clear(eng_clear), .tx_count(tx_count), .busy(busy), .timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected engine timeline.
  bit          e_acc[AS];
  logic [42:0] e_dat[AS];
  bit          e_fin[AS];
  bit          e_clr[AS];
  bit          e_busy[AS];
  int          cnt_set[AS];

  int ptr, cnt, cur_cnt, free_at, wait_lo, wait_hi, done_at, acc_ch, g, d;
  bit exp_r0, exp_r1, found;
  logic [43:0] rec;

  function automatic logic [43:0] rand_rec();
    logic [43:0] r;
    r     = {12'($urandom), $urandom};
    r[43] = ($urandom_range(0, 5) == 0);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < AS; i++) cnt_set[i] = -1;
    ptr = 0; cnt = 0; cur_cnt = 0; free_at = 0;
    wait_lo = -1; wait_hi = -1; done_at = -1;

    // Reset: all outputs low even with inputs active.
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; eng_fin_done = 1'b0;
    req0_data = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1; eng_fin_done = 1'b1;
    @(negedge clk);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_acc", 64'(eng_acc_valid), 64'd0);
    chk("rst_fin", 64'(eng_fin_start), 64'd0);
    chk("rst_clr", 64'(eng_clear), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tmo", 64'(timeout), 64'd0);
    chk("rst_cnt", 64'(tx_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random phase followed by a drain tail.
    for (int c = 0; c < NT; c++) begin
      req0_valid = (c < NC) && ($urandom_range(0, 9) < 6);
      req1_valid = (c < NC) && ($urandom_range(0, 9) < 6);
      req0_data  = rand_rec();
      req1_data  = rand_rec();
      if (c >= wait_lo && c <= wait_hi) eng_fin_done = (c == done_at);
      else                              eng_fin_done = ($urandom_range(0, 7) == 0);

      g      = (ptr == 0 ? req0_valid : req1_valid) ? ptr : 1 - ptr;
      exp_r0 = (c >= free_at) && (g == 0);
      exp_r1 = (c >= free_at) && (g == 1);
      acc_ch = -1;
      if (c >= free_at && (g == 0 ? req0_valid : req1_valid)) acc_ch = g;

      if (acc_ch >= 0) begin
        rec = (acc_ch == 0) ? req0_data : req1_data;
        ptr = 1 - acc_ch;
        d   = $urandom_range(0, 3);
        if (rec[43] && cnt > 0) begin
          e_fin[c + 1] = 1'b1;
          wait_lo = c + 2; done_at = c + 2 + d; wait_hi = done_at;
          e_clr[done_at + 1] = 1'b1;
          e_acc[done_at + 2] = 1'b1;
          e_dat[done_at + 2] = rec[42:0];
          for (int k = c + 1; k <= done_at + 2; k++) e_busy[k] = 1'b1;
          cnt_set[done_at + 2] = 0;
          cnt_set[done_at + 3] = 1;
          cnt = 1;
          free_at = done_at + 3;
        end else begin
          cnt++;
          e_acc[c + 1] = 1'b1;
          e_dat[c + 1] = rec[42:0];
          cnt_set[c + 1] = cnt;
          if (cnt == MAXT) begin
            e_fin[c + 2] = 1'b1;
            wait_lo = c + 3; done_at = c + 3 + d; wait_hi = done_at;
            e_clr[done_at + 1] = 1'b1;
            for (int k = c + 2; k <= done_at + 1; k++) e_busy[k] = 1'b1;
            cnt_set[done_at + 2] = 0;
            cnt = 0;
            free_at = done_at + 2;
          end else begin
            free_at = c + 2;
          end
        end
      end

      @(negedge clk);
      if (cnt_set[c] >= 0) cur_cnt = cnt_set[c];
      chk("ready0", 64'(req0_ready), 64'(exp_r0));
      chk("ready1", 64'(req1_ready), 64'(exp_r1));
      chk("acc_valid", 64'(eng_acc_valid), 64'(e_acc[c]));
      if (e_acc[c]) chk("acc_data", 64'(eng_acc_data), 64'(e_dat[c]));
      chk("fin_start", 64'(eng_fin_start), 64'(e_fin[c]));
      chk("clear", 64'(eng_clear), 64'(e_clr[c]));
      chk("busy", 64'(busy), 64'(e_busy[c]));
      chk("tx_count", 64'(tx_count), 64'(cur_cnt));
      chk("timeout", 64'(timeout), 64'd0);
      @(posedge clk);
      #1;
    end

    // Directed: reset while waiting for the engine.
    req1_valid = 1'b0; eng_fin_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      req0_valid = 1'b1;
      req0_data  = rand_rec();
      req0_data[43] = 1'b1;
      @(negedge clk);
      found = eng_fin_start;
      @(posedge clk);
      #1;
    end
    chk("fin_seen", 64'(found), 64'd1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_clr", 64'(eng_clear), 64'd0);
    chk("midrst_cnt", 64'(tx_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; eng_fin_done = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("post_ready0", 64'(req0_ready), 64'd1);
    chk("post_ready1", 64'(req1_ready), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_cnt", 64'(tx_count), 64'd0);
    chk("post_acc", 64'(eng_acc_valid), 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_clr", 64'(eng_clear), 64'd0);
      chk("post_idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      eng_fin_done = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
